stride_vp_top: RTL and testbench

- Parametrised stride value predictor; successor to the last-value baseline predictor in the VP pipeline.
- Each table entry holds a last value, a signed stride and a confidence counter.
- Predicts last + stride for up to P_NUM_PRED instructions per cycle and trains itself from P_NUM_PRED feedback lanes.
- A post-reset sweep FSM clears the table, replacing per-entry reset.

---
 rtl/stride_vp_top.sv | 172 +++++++++++++++++
 tb/tb_stride_vp_top.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stride_vp_top.sv
// Stride value predictor: each entry keeps last value, signed stride and a confidence counter.
// Predicts last + stride per forward lane and trains from same-width feedback lanes.
module stride_vp_top #(
  parameter int unsigned P_STORAGE_SIZE = 2048,
  parameter int unsigned P_CONF_WIDTH   = 8,
  parameter int unsigned P_STRIDE_WIDTH = 16,
  parameter int unsigned P_NUM_PRED     = 2
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic [P_NUM_PRED-1:0][31:1]              fw_pc_i,
  input  logic [P_NUM_PRED-1:0]                    fw_valid_i,
  output logic [P_NUM_PRED-1:0][31:1]              pred_pc_o,
  output logic [P_NUM_PRED-1:0][31:0]              pred_result_o,
  output logic [P_NUM_PRED-1:0][P_CONF_WIDTH:0]    pred_conf_o,
  output logic [P_NUM_PRED-1:0]                    pred_valid_o,
  input  logic [P_NUM_PRED-1:0][31:1]              fb_pc_i,
  input  logic [P_NUM_PRED-1:0][31:0]              fb_actual_i,
  input  logic [P_NUM_PRED-1:0]                    fb_valid_i,
  output logic                                     init_done_o
);

  localparam int unsigned P_INDEX_WIDTH = $clog2(P_STORAGE_SIZE);
  localparam int unsigned IW = P_INDEX_WIDTH;
  localparam int unsigned SW = P_STRIDE_WIDTH;
  localparam int unsigned CW = P_CONF_WIDTH + 1;
  localparam int unsigned NP = P_NUM_PRED;

  typedef enum logic {StInit, StRun} state_e;

  typedef struct packed {
    logic [31:0]   last;
    logic [SW-1:0] stride;
    logic [CW-1:0] conf;
  } entry_t;

  function automatic logic [31:0] f_sext(input logic [SW-1:0] v);
    logic signed [SW-1:0] s;
    s = v;
    return 32'(s);
  endfunction

  function automatic entry_t f_update(input entry_t e, input logic [31:0] actual);
    logic [31:0]   diff;
    logic [SW-1:0] lo;
    entry_t        n;
    diff   = actual - e.last;
    lo     = diff[SW-1:0];
    n      = e;
    n.last = actual;
    if (f_sext(lo) != diff) begin
      n.stride = '0;
      n.conf   = '0;
    end else if (lo == e.stride) begin
      // MSB set means saturated at 2^P_CONF_WIDTH
      if (!e.conf[CW-1]) n.conf = e.conf + CW'(1);
    end else begin
      n.stride = lo;
      n.conf   = '0;
    end
    return n;
  endfunction

  state_e               r_state;
  logic [IW-1:0]        r_sweep;
  logic                 r_init_done;
  entry_t               r_table [P_STORAGE_SIZE];

  logic [NP-1:0][31:1]   r_pred_pc;
  logic [NP-1:0][31:0]   r_pred_result;
  logic [NP-1:0][CW-1:0] r_pred_conf;
  logic [NP-1:0]         r_pred_valid;

  logic [IW-1:0]        w_fb_idx [NP];
  entry_t               w_fb_upd [NP];
  logic [NP-1:0]        w_fb_we;
  logic                 w_run;
  logic                 w_unused;

  assign w_run    = (r_state == StRun);
  assign w_unused = ^fb_pc_i;

  // Forwarding chain: lane p starts from the entry left by the highest lower valid lane on
  // the same index; only the last such lane in program order commits the write.
  always_comb begin
    logic [IW-1:0] w_idx  [NP];
    entry_t        w_view [NP];
    entry_t        w_upd  [NP];
    logic [NP-1:0] w_we;
    for (int p = 0; p < NP; p++) begin
      w_idx[p] = fb_pc_i[p][IW:1];
    end
    for (int p = 0; p < NP; p++) begin
      w_view[p] = r_table[w_idx[p]];
      for (int q = 0; q < p; q++) begin
        if (fb_valid_i[q] && (w_idx[q] == w_idx[p])) w_view[p] = w_upd[q];
      end
      w_upd[p] = f_update(w_view[p], fb_actual_i[p]);
    end
    for (int p = 0; p < NP; p++) begin
      w_we[p] = fb_valid_i[p] & w_run;
      for (int q = p + 1; q < NP; q++) begin
        if (fb_valid_i[q] && (w_idx[q] == w_idx[p])) w_we[p] = 1'b0;
      end
    end
    for (int p = 0; p < NP; p++) begin
      w_fb_idx[p] = w_idx[p];
      w_fb_upd[p] = w_upd[p];
    end
    w_fb_we = w_we;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StInit;
      r_sweep     <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        StInit: begin
          r_sweep <= r_sweep + IW'(1);
          if (r_sweep == IW'(P_STORAGE_SIZE - 1)) begin
            r_state     <= StRun;
            r_init_done <= 1'b1;
          end
        end
        StRun: begin
          r_init_done <= 1'b1;
        end
        default: begin
          r_state <= StInit;
        end
      endcase
    end
  end

  // Table storage carries no reset; the sweep clears it instead.
  always_ff @(posedge clk_i) begin
    if (r_state == StInit) begin
      r_table[r_sweep] <= '0;
    end
    for (int p = 0; p < NP; p++) begin
      if (w_fb_we[p]) r_table[w_fb_idx[p]] <= w_fb_upd[p];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pred_pc     <= '0;
      r_pred_result <= '0;
      r_pred_conf   <= '0;
      r_pred_valid  <= '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        r_pred_pc[p]    <= fw_pc_i[p];
        r_pred_valid[p] <= fw_valid_i[p] & w_run;
        if (fw_valid_i[p] && w_run) begin
          r_pred_result[p] <= r_table[fw_pc_i[p][IW:1]].last +
                              f_sext(r_table[fw_pc_i[p][IW:1]].stride);
          r_pred_conf[p]   <= r_table[fw_pc_i[p][IW:1]].conf;
        end
      end
    end
  end

  assign pred_pc_o     = r_pred_pc;
  assign pred_result_o = r_pred_result;
  assign pred_conf_o   = r_pred_conf;
  assign pred_valid_o  = r_pred_valid;
  assign init_done_o   = r_init_done;

endmodule

// File: tb/tb_stride_vp_top.sv
// Directed bench for stride_vp_top: sweep timing, stride training, saturation,
// same-cycle lane chaining, read-before-write and mid-sweep reset.
module tb_stride_vp_top;

  localparam int unsigned SZ = 16;
  localparam int unsigned CWD = 2;
  localparam int unsigned SWD = 8;
  localparam int unsigned NP = 2;

  logic                       clk_i = 1'b0;
  logic                       rst_ni = 1'b1;
  logic [NP-1:0][31:1]        fw_pc_i = '0;
  logic [NP-1:0]              fw_valid_i = '0;
  logic [NP-1:0][31:1]        pred_pc_o;
  logic [NP-1:0][31:0]        pred_result_o;
  logic [NP-1:0][CWD:0]       pred_conf_o;
  logic [NP-1:0]              pred_valid_o;
  logic [NP-1:0][31:1]        fb_pc_i = '0;
  logic [NP-1:0][31:0]        fb_actual_i = '0;
  logic [NP-1:0]              fb_valid_i = '0;
  logic                       init_done_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  stride_vp_top #(
    .P_STORAGE_SIZE (SZ),
    .P_CONF_WIDTH   (CWD),
    .P_STRIDE_WIDTH (SWD),
    .P_NUM_PRED     (NP)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .fw_pc_i       (fw_pc_i),
    .fw_valid_i    (fw_valid_i),
    .pred_pc_o     (pred_pc_o),
    .pred_result_o (pred_result_o),
    .pred_conf_o   (pred_conf_o),
    .pred_valid_o  (pred_valid_o),
    .fb_pc_i       (fb_pc_i),
    .fb_actual_i   (fb_actual_i),
    .fb_valid_i    (fb_valid_i),
    .init_done_o   (init_done_o)
  );

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_in;
    fw_valid_i = '0;
    fb_valid_i = '0;
  endtask

  task automatic drive_fb(input int lane, input logic [31:0] pc, input logic [31:0] val);
    fb_pc_i[lane]     = pc[31:1];
    fb_actual_i[lane] = val;
    fb_valid_i[lane]  = 1'b1;
  endtask

  task automatic drive_fw(input int lane, input logic [31:0] pc);
    fw_pc_i[lane]    = pc[31:1];
    fw_valid_i[lane] = 1'b1;
  endtask

  task automatic feed(input logic [31:0] pc, input logic [31:0] val);
    clear_in;
    drive_fb(0, pc, val);
    step;
    clear_in;
  endtask

  // Leaves pc 0x8 at last 100, stride 4, conf 1 from any modest prior state.
  task automatic setup_pc8;
    feed(32'h8, 32'd5000);
    feed(32'h8, 32'd92);
    feed(32'h8, 32'd96);
    feed(32'h8, 32'd100);
  endtask

  task automatic test_reset;
    drive_fw(0, 32'h10);
    drive_fw(1, 32'h8);
    drive_fb(0, 32'h10, 32'd55);
    #1 rst_ni = 1'b0;
    #11;
    checks++; if (pred_valid_o !== 2'b00 || init_done_o !== 1'b0 || pred_pc_o !== '0) begin
      errors++; $display("FAIL reset_out: valid %b done %b pc %h, expected all zero",
                         pred_valid_o, init_done_o, pred_pc_o); end
    step;
    rst_ni = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step;
      checks++; if (init_done_o !== (i == 16)) begin
        errors++; $display("FAIL init_done cycle %0d: got %b expected %b", i, init_done_o,
                           (i == 16)); end
      checks++; if (pred_valid_o !== 2'b00) begin
        errors++; $display("FAIL init_valid cycle %0d: got %b expected 00", i, pred_valid_o); end
    end
    fb_valid_i = '0;
    step;
    checks++; if (pred_valid_o !== 2'b11) begin
      errors++; $display("FAIL run_valid: got %b expected 11", pred_valid_o); end
    checks++; if (pred_result_o[0] !== 32'd0 || pred_conf_o[0] !== 3'd0) begin
      errors++; $display("FAIL clear_entry: got %0d/%0d expected 0/0", pred_result_o[0],
                         pred_conf_o[0]); end
    checks++; if (pred_pc_o[0] !== 31'h8) begin
      errors++; $display("FAIL pred_pc: got %h expected 8", pred_pc_o[0]); end
    clear_in;
  endtask

  task automatic test_stride;
    logic [31:0] vals  [6] = '{32'd100, 32'd104, 32'd108, 32'd112, 32'd116, 32'd120};
    logic [31:0] exp_r [6] = '{32'd0, 32'd200, 32'd108, 32'd112, 32'd116, 32'd120};
    logic [2:0]  exp_c [6] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3};
    for (int k = 0; k < 6; k++) begin
      clear_in;
      drive_fb(0, 32'h8, vals[k]);
      drive_fw(1, 32'h8);
      step;
      checks++; if (pred_result_o[1] !== exp_r[k] || pred_conf_o[1] !== exp_c[k]) begin
        errors++; $display("FAIL train step %0d: got %0d/%0d expected %0d/%0d", k,
                           pred_result_o[1], pred_conf_o[1], exp_r[k], exp_c[k]); end
    end
    clear_in;
    drive_fw(0, 32'h8);
    step;
    checks++; if (pred_result_o[0] !== 32'd124 || pred_conf_o[0] !== 3'd4) begin
      errors++; $display("FAIL trained_pred: got %0d/%0d expected 124/4", pred_result_o[0],
                         pred_conf_o[0]); end
    clear_in;
  endtask

  task automatic test_retrain;
    logic [31:0] vals  [3] = '{32'd200, 32'd1000, 32'd990};
    logic [31:0] exp_r [3] = '{32'd280, 32'd1000, 32'd980};
    for (int k = 0; k < 3; k++) begin
      feed(32'h8, vals[k]);
      drive_fw(0, 32'h8);
      step;
      checks++; if (pred_result_o[0] !== exp_r[k] || pred_conf_o[0] !== 3'd0) begin
        errors++; $display("FAIL retrain %0d: got %0d/%0d expected %0d/0", k,
                           pred_result_o[0], pred_conf_o[0], exp_r[k]); end
      clear_in;
    end
    for (int k = 1; k <= 7; k++) feed(32'h10, 32'(10 * k));
    drive_fw(0, 32'h10);
    step;
    checks++; if (pred_result_o[0] !== 32'd80 || pred_conf_o[0] !== 3'd4) begin
      errors++; $display("FAIL saturate: got %0d/%0d expected 80/4", pred_result_o[0],
                         pred_conf_o[0]); end
    clear_in;
  endtask

  task automatic test_dual_lane;
    setup_pc8;
    drive_fb(0, 32'h8, 32'd104);
    drive_fb(1, 32'h8, 32'd108);
    step;
    clear_in;
    drive_fw(0, 32'h8);
    step;
    checks++; if (pred_result_o[0] !== 32'd112 || pred_conf_o[0] !== 3'd3) begin
      errors++; $display("FAIL chain_both: got %0d/%0d expected 112/3", pred_result_o[0],
                         pred_conf_o[0]); end
    clear_in;
    setup_pc8;
    fb_pc_i[0] = 31'h4;
    fb_actual_i[0] = 32'd104;
    drive_fb(1, 32'h8, 32'd108);
    step;
    clear_in;
    drive_fw(1, 32'h8);
    step;
    checks++; if (pred_result_o[1] !== 32'd116 || pred_conf_o[1] !== 3'd0) begin
      errors++; $display("FAIL chain_lane0_off: got %0d/%0d expected 116/0", pred_result_o[1],
                         pred_conf_o[1]); end
    clear_in;
  endtask

  task automatic test_back_to_back;
    drive_fb(0, 32'h8, 32'd116);
    drive_fb(1, 32'hC, 32'd7);
    step;
    clear_in;
    drive_fw(0, 32'h8);
    drive_fw(1, 32'hC);
    step;
    checks++; if (pred_result_o[0] !== 32'd124 || pred_conf_o[0] !== 3'd1) begin
      errors++; $display("FAIL split_lane0: got %0d/%0d expected 124/1", pred_result_o[0],
                         pred_conf_o[0]); end
    checks++; if (pred_result_o[1] !== 32'd14 || pred_conf_o[1] !== 3'd0) begin
      errors++; $display("FAIL split_lane1: got %0d/%0d expected 14/0", pred_result_o[1],
                         pred_conf_o[1]); end
    clear_in;
  endtask

  task automatic test_rbw;
    setup_pc8;
    drive_fb(0, 32'h8, 32'd104);
    drive_fw(0, 32'h8);
    step;
    checks++; if (pred_result_o[0] !== 32'd104 || pred_conf_o[0] !== 3'd1) begin
      errors++; $display("FAIL rbw_old: got %0d/%0d expected 104/1", pred_result_o[0],
                         pred_conf_o[0]); end
    fb_valid_i = '0;
    step;
    checks++; if (pred_result_o[0] !== 32'd108 || pred_conf_o[0] !== 3'd2) begin
      errors++; $display("FAIL rbw_new: got %0d/%0d expected 108/2", pred_result_o[0],
                         pred_conf_o[0]); end
    clear_in;
  endtask

  task automatic test_reset_mid;
    drive_fw(0, 32'h10);
    drive_fw(1, 32'h8);
    step;
    rst_ni = 1'b0;
    #1;
    checks++; if (pred_valid_o !== 2'b00 || pred_result_o !== '0 || pred_conf_o !== '0 ||
                  init_done_o !== 1'b0) begin
      errors++; $display("FAIL async_reset: valid %b res %h conf %h done %b, expected zero",
                         pred_valid_o, pred_result_o, pred_conf_o, init_done_o); end
    step;
    rst_ni = 1'b1;
    for (int i = 0; i < 7; i++) step;
    rst_ni = 1'b0;
    #1;
    checks++; if (pred_pc_o !== '0) begin
      errors++; $display("FAIL mid_sweep_reset: pc %h expected 0", pred_pc_o); end
    step;
    rst_ni = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step;
      checks++; if (init_done_o !== (i == 16)) begin
        errors++; $display("FAIL restart_done cycle %0d: got %b expected %b", i, init_done_o,
                           (i == 16)); end
    end
    step;
    checks++; if (pred_valid_o !== 2'b11 || pred_result_o[0] !== 32'd0 ||
                  pred_conf_o[0] !== 3'd0 || pred_result_o[1] !== 32'd0) begin
      errors++; $display("FAIL resweep_clear: valid %b res %0d/%0d conf %0d expected 11 0/0 0",
                         pred_valid_o, pred_result_o[0], pred_result_o[1], pred_conf_o[0]); end
    clear_in;
  endtask

  initial begin
    test_reset;
    test_stride;
    test_retrain;
    test_dual_lane;
    test_back_to_back;
    test_rbw;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
